// File: rtl/cgu_fdupdate_seq_pkg.sv
`default_nettype none
// ============================================================================
// cgu_pkg : shared types and constants for the clktop / fd update sequencer
// Revision: 1.0
// ============================================================================
package cgu_pkg;

   localparam int CGU_OCNT = 6;
   localparam int CGU_FDW  = 8;

   typedef bit [0:CGU_OCNT-1][CGU_FDW-1:0] fdvec_t;

   typedef enum logic [2:0] {
      ST_IDLE    = 3'd0,
      ST_LATCH   = 3'd1,
      ST_SELPLS  = 3'd2,
      ST_SELWAIT = 3'd3,
      ST_SETTLE  = 3'd4,
      ST_FDPLS   = 3'd5,
      ST_DONE    = 3'd6
   } seq_state_e;

   localparam logic SEL_CLKSYS = 1'b0;
   localparam logic SEL_PLL0   = 1'b1;

   localparam logic [CGU_FDW-1:0] FD_RST_FIELD = CGU_FDW'('h7F);
   localparam logic [CGU_FDW-1:0] FD_RST_LAST  = CGU_FDW'('hF);
   localparam fdvec_t FDRST_DEFAULT = {{(CGU_OCNT-1){FD_RST_FIELD}}, FD_RST_LAST};

   // Settled switch enables, bit order [0:1]: pll0 selected -> 01, clksys -> 10.
   function automatic logic [0:1] topselen_expect(input logic sel);
      return (sel == SEL_PLL0) ? 2'b01 : 2'b10;
   endfunction

endpackage
`default_nettype wire

// File: rtl/cgu_fdupdate_seq_sync2.sv
`default_nettype none
// ============================================================================
// cgu_sync2 : two-flop synchronizer, async active-high reset
// Revision: 1.0
// ============================================================================
module cgu_sync2 #(
   parameter int W = 2
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d_i,
   output logic [W-1:0] q_o
);

   logic [W-1:0] meta_q;
   logic [W-1:0] sync_q;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         meta_q <= '0;
         sync_q <= '0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule
`default_nettype wire

// File: rtl/cgu_fdupdate_seq.sv
`default_nettype none
// ============================================================================
// cgu_fdupdate_seq : orders a top-clock switch and a divider load for the core
// Revision: 1.0
// ============================================================================
module cgu_fdupdate_seq
   import cgu_pkg::*;
#(
   parameter int                  OCNT   = CGU_OCNT,
   parameter int                  FDW    = CGU_FDW,
   parameter int                  SETTLE = 16,
   parameter int                  TMO    = 1024,
   parameter logic [OCNT*FDW-1:0] FDRST  = FDRST_DEFAULT
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                req,
   input  logic                req_topsel,
   input  logic [OCNT*FDW-1:0] req_fd,
   input  logic [0:1]          topselen,
   output logic [OCNT*FDW-1:0] fd_o,
   output logic                clktopsel,
   output logic                clktopselupdate,
   output logic                fdload,
   output logic                busy,
   output logic                done,
   output logic                err_busy,
   output logic                err_tmo
);

   localparam logic [15:0] TMO_LOAD    = 16'(TMO - 1);
   localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE - 1);
   // FDPLS spans three cycles: new fd visible, fdload strobe, hold.
   localparam logic [15:0] FDPLS_LOAD  = 16'd2;

   seq_state_e          state_q, state_d;
   logic [15:0]         cnt_q, cnt_d;
   logic                sh_topsel_q;
   logic [OCNT*FDW-1:0] sh_fd_q;
   logic [OCNT*FDW-1:0] fd_q;
   logic                clktopsel_q;
   logic                upd_q, upd_d;
   logic                fdload_q, fdload_d;
   logic                busy_q, busy_d;
   logic                done_q, done_d;
   logic                err_busy_q, err_busy_d;
   logic                err_tmo_q, err_tmo_d;
   logic                match_prev_q;

   logic [0:1]          topselen_s;
   logic                accept;
   logic                cnt_zero;
   logic                match_now;
   logic                confirm;
   logic                load_sel;
   logic                load_fd;
   logic                tmo_hit;

   cgu_sync2 #(.W(2)) u_sync (
      .clk   (clk),
      .reset (reset),
      .d_i   (topselen),
      .q_o   (topselen_s)
   );

   assign accept    = req && (state_q == ST_IDLE);
   assign cnt_zero  = (cnt_q == 16'd0);
   assign match_now = (topselen_s == topselen_expect(clktopsel_q));
   assign confirm   = match_now && match_prev_q;

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_zero ? cnt_q : cnt_q - 16'd1;
      load_sel = 1'b0;
      load_fd  = 1'b0;
      tmo_hit  = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (accept) state_d = ST_LATCH;
         end
         ST_LATCH: begin
            if (sh_topsel_q != clktopsel_q) begin
               state_d  = ST_SELPLS;
               load_sel = 1'b1;
            end else begin
               state_d = ST_FDPLS;
               cnt_d   = FDPLS_LOAD;
               load_fd = 1'b1;
            end
         end
         ST_SELPLS: begin
            state_d = ST_SELWAIT;
            cnt_d   = TMO_LOAD;
         end
         ST_SELWAIT: begin
            if (confirm) begin
               state_d = ST_SETTLE;
               cnt_d   = SETTLE_LOAD;
            end else if (cnt_zero) begin
               state_d = ST_DONE;
               tmo_hit = 1'b1;
            end
         end
         ST_SETTLE: begin
            if (cnt_zero) begin
               state_d = ST_FDPLS;
               cnt_d   = FDPLS_LOAD;
               load_fd = 1'b1;
            end
         end
         ST_FDPLS: begin
            if (cnt_zero) state_d = ST_DONE;
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // All outputs are registered from next-state so the core sees clean strobes.
      upd_d      = load_sel;
      fdload_d   = (state_q == ST_FDPLS) && (cnt_q == FDPLS_LOAD);
      done_d     = (state_d == ST_DONE);
      busy_d     = (state_d != ST_IDLE) && (state_d != ST_DONE);
      err_busy_d = accept ? 1'b0 : (err_busy_q | (req & busy_q));
      err_tmo_d  = accept ? 1'b0 : (err_tmo_q | tmo_hit);
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_IDLE;
         cnt_q        <= 16'd0;
         sh_topsel_q  <= SEL_CLKSYS;
         sh_fd_q      <= FDRST;
         fd_q         <= FDRST;
         clktopsel_q  <= SEL_CLKSYS;
         upd_q        <= 1'b0;
         fdload_q     <= 1'b0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         err_busy_q   <= 1'b0;
         err_tmo_q    <= 1'b0;
         match_prev_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         upd_q      <= upd_d;
         fdload_q   <= fdload_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         err_busy_q <= err_busy_d;
         err_tmo_q  <= err_tmo_d;
         if (accept) begin
            sh_topsel_q <= req_topsel;
            sh_fd_q     <= req_fd;
         end
         if (load_sel) clktopsel_q <= sh_topsel_q;
         if (load_fd)  fd_q        <= sh_fd_q;
         // Stale synchronizer contents must not count toward the new confirm.
         match_prev_q <= (state_q == ST_SELPLS) ? 1'b0 : match_now;
      end
   end

   assign fd_o            = fd_q;
   assign clktopsel       = clktopsel_q;
   assign clktopselupdate = upd_q;
   assign fdload          = fdload_q;
   assign busy            = busy_q;
   assign done            = done_q;
   assign err_busy        = err_busy_q;
   assign err_tmo         = err_tmo_q;

endmodule
`default_nettype wire
